// File: rtl/button_conditioner.sv
// Input conditioning for the pet controller: 2-FF sync, debounce, press pulses and test-entry gesture decoding.
// Build option: define GIRO_DEBOUNCE_EN to debounce the tilt switch like the buttons.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES    = 50000,
  parameter int unsigned LONG_PRESS_CYCLES  = 150000000,
  parameter int unsigned TEST_WINDOW_CYCLES = 75000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_sleep_raw,
  input  logic       btn_awake_raw,
  input  logic       btn_feed_raw,
  input  logic       btn_play_raw,
  input  logic       btn_test_raw,
  input  logic       giro_raw,
  output logic       sleep_pulse,
  output logic       awake_pulse,
  output logic       feed_pulse,
  output logic       play_pulse,
  output logic       giro_level,
  output logic       test_req,
  output logic [3:0] pulse_test,
  output logic       pulse_test_valid
);

  localparam int unsigned NRAW    = 6;
  localparam int unsigned CH_TEST = 4;
  localparam int unsigned CH_GIRO = 5;
`ifdef GIRO_DEBOUNCE_EN
  localparam int unsigned NDB = 6;
`else
  localparam int unsigned NDB = 5;
`endif
  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES    > 1) ? $clog2(DEBOUNCE_CYCLES)    : 1;
  localparam int unsigned HOLD_W = (LONG_PRESS_CYCLES  > 1) ? $clog2(LONG_PRESS_CYCLES)  : 1;
  localparam int unsigned WIN_W  = (TEST_WINDOW_CYCLES > 1) ? $clog2(TEST_WINDOW_CYCLES) : 1;
  localparam logic [3:0]  COUNT_MAX = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_WAIT_REL,
    S_COLLECT
  } state_t;

  logic [NRAW-1:0] w_raw;
  logic [NRAW-1:0] r_sync1;
  logic [NRAW-1:0] r_sync2;
  logic [NDB-1:0]  r_stable;
  logic [NDB-1:0]  w_toggle;
  logic [DB_W-1:0] r_db_cnt [NDB];
  logic [3:0]      r_stable_d;
  logic [3:0]      r_pulse;

  assign w_raw = {giro_raw, btn_test_raw, btn_play_raw, btn_feed_raw, btn_awake_raw, btn_sleep_raw};

  // Two-flop synchroniser on every raw input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A channel toggles once its mismatch has persisted for the full debounce time
  always_comb begin
    w_toggle = '0;
    for (int c = 0; c < int'(NDB); c++) begin
      w_toggle[c] = (r_sync2[c] != r_stable[c]) &&
                    (r_db_cnt[c] == DB_W'(DEBOUNCE_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable <= '0;
      for (int c = 0; c < int'(NDB); c++) r_db_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < int'(NDB); c++) begin
        if (r_sync2[c] == r_stable[c]) begin
          r_db_cnt[c] <= '0;
        end else if (w_toggle[c]) begin
          r_stable[c] <= ~r_stable[c];
          r_db_cnt[c] <= '0;
        end else begin
          r_db_cnt[c] <= r_db_cnt[c] + DB_W'(1);
        end
      end
    end
  end

  // Rising-edge pulses for the four command buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable_d <= '0;
      r_pulse    <= '0;
    end else begin
      r_stable_d <= r_stable[3:0];
      r_pulse    <= r_stable[3:0] & ~r_stable_d;
    end
  end

  assign sleep_pulse = r_pulse[0];
  assign awake_pulse = r_pulse[1];
  assign feed_pulse  = r_pulse[2];
  assign play_pulse  = r_pulse[3];

`ifdef GIRO_DEBOUNCE_EN
  assign giro_level = r_stable[CH_GIRO];
`else
  assign giro_level = r_sync2[CH_GIRO];
`endif

  // Test gesture decoder; edges are taken as the stable level flips so timers start on that edge
  logic              w_test_rise;
  logic              w_test_fall;
  state_t            r_state,      w_state;
  logic [HOLD_W-1:0] r_hold_cnt,   w_hold_cnt;
  logic [WIN_W-1:0]  r_win_cnt,    w_win_cnt;
  logic [3:0]        r_count,      w_count;
  logic [3:0]        r_pulse_test, w_pulse_test;
  logic              r_test_req,   w_test_req;
  logic              r_valid,      w_valid;

  assign w_test_rise = w_toggle[CH_TEST] & ~r_stable[CH_TEST];
  assign w_test_fall = w_toggle[CH_TEST] &  r_stable[CH_TEST];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_hold_cnt   <= '0;
      r_win_cnt    <= '0;
      r_count      <= '0;
      r_pulse_test <= '0;
      r_test_req   <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_hold_cnt   <= w_hold_cnt;
      r_win_cnt    <= w_win_cnt;
      r_count      <= w_count;
      r_pulse_test <= w_pulse_test;
      r_test_req   <= w_test_req;
      r_valid      <= w_valid;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_hold_cnt   = r_hold_cnt;
    w_win_cnt    = r_win_cnt;
    w_count      = r_count;
    w_pulse_test = r_pulse_test;
    w_test_req   = 1'b0;
    w_valid      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_test_rise) begin
          w_state    = S_HOLD;
          w_hold_cnt = '0;
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == HOLD_W'(LONG_PRESS_CYCLES - 1)) begin
          w_test_req   = 1'b1;
          w_pulse_test = '0;
          w_hold_cnt   = '0;
          w_state      = S_WAIT_REL;
        end else if (w_test_fall) begin
          w_hold_cnt = '0;
          w_state    = S_IDLE;
        end else begin
          w_hold_cnt = r_hold_cnt + HOLD_W'(1);
        end
      end
      S_WAIT_REL: begin
        // Level rather than edge: the release may coincide with long-press recognition
        if (!r_stable[CH_TEST]) begin
          w_count   = '0;
          w_win_cnt = '0;
          w_state   = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (w_test_rise) begin
          w_count   = (r_count == COUNT_MAX) ? COUNT_MAX : r_count + 4'd1;
          w_win_cnt = '0;
        end else if (r_win_cnt == WIN_W'(TEST_WINDOW_CYCLES - 1)) begin
          if (r_count != 4'd0) begin
            w_pulse_test = r_count;
            w_valid      = 1'b1;
          end
          w_count   = '0;
          w_win_cnt = '0;
          w_state   = S_IDLE;
        end else begin
          w_win_cnt = r_win_cnt + WIN_W'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign test_req         = r_test_req;
  assign pulse_test       = r_pulse_test;
  assign pulse_test_valid = r_valid;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed gesture scenarios plus random bouncing inputs vs a timestamp model.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int L = 20;
  localparam int W = 30;

  localparam int M_IDLE = 0;
  localparam int M_HOLD = 1;
  localparam int M_REL  = 2;
  localparam int M_COLL = 3;

  logic       clk;
  logic       rst;
  logic [5:0] raw;
  logic       sleep_pulse, awake_pulse, feed_pulse, play_pulse;
  logic       giro_level, test_req, pulse_test_valid;
  logic [3:0] pulse_test;

  button_conditioner #(
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (L),
    .TEST_WINDOW_CYCLES(W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_sleep_raw   (raw[0]),
    .btn_awake_raw   (raw[1]),
    .btn_feed_raw    (raw[2]),
    .btn_play_raw    (raw[3]),
    .btn_test_raw    (raw[4]),
    .giro_raw        (raw[5]),
    .sleep_pulse     (sleep_pulse),
    .awake_pulse     (awake_pulse),
    .feed_pulse      (feed_pulse),
    .play_pulse      (play_pulse),
    .giro_level      (giro_level),
    .test_req        (test_req),
    .pulse_test      (pulse_test),
    .pulse_test_valid(pulse_test_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a level is accepted once the synchronised input (raw two edges back)
  // has disagreed with it on D consecutive edges; gesture timing is kept as timestamps.
  logic [5:0] m_hist [0:D+1];
  logic [5:0] m_stab, m_old, m_up, m_dn, m_rise_prev;
  logic       m_diff;
  int         m_n, m_mode, m_t_hold, m_t_last, m_cnt;
  logic [3:0] e_pulse = '0;
  logic       e_giro = 1'b0, e_req = 1'b0, e_valid = 1'b0;
  int         e_pt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j <= D + 1; j++) m_hist[j] = '0;
      m_stab = '0; m_rise_prev = '0;
      e_pulse = '0; e_giro = 1'b0; e_req = 1'b0; e_valid = 1'b0; e_pt = 0;
      m_mode = M_IDLE; m_n = 0; m_t_hold = 0; m_t_last = 0; m_cnt = 0;
    end else begin
      m_n = m_n + 1;
      for (int j = D + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = raw;
      m_old = m_stab;
      for (int c = 0; c < 6; c++) begin
        m_diff = 1'b1;
        for (int i = 0; i < D; i++) if (m_hist[i+2][c] == m_old[c]) m_diff = 1'b0;
        if (m_diff) m_stab[c] = ~m_old[c];
      end
      m_up = m_stab & ~m_old;
      m_dn = ~m_stab & m_old;
      e_pulse = m_rise_prev[3:0];
      m_rise_prev = m_up;
`ifdef GIRO_DEBOUNCE_EN
      e_giro = m_stab[5];
`else
      e_giro = m_hist[1][5];
`endif
      e_req = 1'b0;
      e_valid = 1'b0;
      case (m_mode)
        M_IDLE: if (m_up[4]) begin m_mode = M_HOLD; m_t_hold = m_n; end
        M_HOLD: begin
          if (m_n == m_t_hold + L) begin
            e_req = 1'b1; e_pt = 0; m_mode = M_REL;
          end else if (m_dn[4]) m_mode = M_IDLE;
        end
        M_REL: if (!m_old[4]) begin m_mode = M_COLL; m_cnt = 0; m_t_last = m_n; end
        default: begin
          if (m_up[4]) begin
            m_cnt = (m_cnt >= 9) ? 9 : m_cnt + 1;
            m_t_last = m_n;
          end else if (m_n == m_t_last + W) begin
            if (m_cnt > 0) begin e_pt = m_cnt; e_valid = 1'b1; end
            m_mode = M_IDLE;
          end
        end
      endcase
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int n_sleep = 0, n_awake = 0, n_feed = 0, n_play = 0, n_req = 0, n_valid = 0;
  int sleep_at = -1, feed_at = -1, play_at = -1, req_at = -1, valid_at = -1;
  int dur [6];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: compare every output against the model on the falling edge and log events
  task automatic step();
    @(negedge clk);
    check("sleep_pulse", int'(sleep_pulse), int'(e_pulse[0]));
    check("awake_pulse", int'(awake_pulse), int'(e_pulse[1]));
    check("feed_pulse",  int'(feed_pulse),  int'(e_pulse[2]));
    check("play_pulse",  int'(play_pulse),  int'(e_pulse[3]));
    check("giro_level",  int'(giro_level),  int'(e_giro));
    check("test_req",    int'(test_req),    int'(e_req));
    check("pulse_test",  int'(pulse_test),  e_pt);
    check("pt_valid",    int'(pulse_test_valid), int'(e_valid));
    if (sleep_pulse) begin n_sleep++; sleep_at = cyc; end
    if (awake_pulse) n_awake++;
    if (feed_pulse)  begin n_feed++;  feed_at = cyc; end
    if (play_pulse)  begin n_play++;  play_at = cyc; end
    if (test_req)    begin n_req++;   req_at = cyc; end
    if (pulse_test_valid) begin n_valid++; valid_at = cyc; end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic long_press();
    raw[4] = 1'b1; run(25);
    raw[4] = 1'b0; run(10);
  endtask

  task automatic short_presses(input int k, output int last_rise);
    last_rise = cyc;
    repeat (k) begin
      last_rise = cyc;
      raw[4] = 1'b1; run(8);
      raw[4] = 1'b0; run(10);
    end
  endtask

  initial begin
    int t0, tl, s0, a0, f0, p0, r0, v0;
    raw = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    run(3);
    check("rst_pulse_test", int'(pulse_test), 0);
    check("rst_giro", int'(giro_level), 0);
    rst = 1'b0;
    run(5);

    // Single feed press: one pulse, 2+D+1 cycles after the raw rise
    s0 = n_sleep; f0 = n_feed; p0 = n_play; t0 = cyc;
    raw[2] = 1'b1; run(10);
    raw[2] = 1'b0; run(15);
    check("feed_count", n_feed - f0, 1);
    check("feed_latency", feed_at - t0, 3 + D);
    check("feed_others", (n_sleep - s0) + (n_play - p0), 0);

    // Bouncing play button is rejected
    p0 = n_play;
    repeat (3) begin
      raw[3] = 1'b1; run(2);
      raw[3] = 1'b0; run(2);
    end
    run(15);
    check("bounce_rejected", n_play - p0, 0);

    // Simultaneous presses pulse together
    s0 = n_sleep; p0 = n_play;
    raw[0] = 1'b1; raw[3] = 1'b1; run(10);
    raw[0] = 1'b0; raw[3] = 1'b0; run(15);
    check("simul_sleep", n_sleep - s0, 1);
    check("simul_play", n_play - p0, 1);
    check("simul_same_cycle", sleep_at, play_at);

    // Long press then three presses -> scenario 3
    r0 = n_req; v0 = n_valid; t0 = cyc;
    long_press();
    short_presses(3, tl);
    run(40);
    check("req_count", n_req - r0, 1);
    check("req_latency", req_at - t0, 2 + D + L);
    check("valid_count3", n_valid - v0, 1);
    check("valid_latency", valid_at - tl, 2 + D + W);
    check("scenario3", int'(pulse_test), 3);

    // Twelve presses saturate at 9
    v0 = n_valid;
    long_press();
    short_presses(12, tl);
    run(40);
    check("valid_count9", n_valid - v0, 1);
    check("scenario_sat", int'(pulse_test), 9);

    // Long press without presses clears the scenario and emits no strobe
    r0 = n_req; v0 = n_valid;
    long_press();
    run(60);
    check("empty_req", n_req - r0, 1);
    check("empty_valid", n_valid - v0, 0);
    check("empty_pt", int'(pulse_test), 0);

    // Reset during collection discards it; a button held through reset still pulses once
    long_press();
    short_presses(2, tl);
    raw[1] = 1'b1; rst = 1'b1;
    run(3);
    check("rst_mid_pt", int'(pulse_test), 0);
    check("rst_mid_valid", int'(pulse_test_valid), 0);
    rst = 1'b0;
    a0 = n_awake; v0 = n_valid; r0 = n_req;
    run(50);
    raw[1] = 1'b0; run(10);
    check("held_through_rst", n_awake - a0, 1);
    check("rst_no_strobe", n_valid - v0, 0);
    check("rst_no_req", n_req - r0, 0);

    // Random bouncing on all inputs, occasional resets
    for (int c = 0; c < 6; c++) dur[c] = $urandom_range(1, 10);
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < 6; c++) begin
        if (dur[c] == 0) begin
          raw[c] = ~raw[c];
          if (c == 4 && $urandom_range(0, 5) == 0) dur[c] = $urandom_range(18, 30);
          else if ($urandom_range(0, 9) < 4) dur[c] = $urandom_range(1, 3);
          else dur[c] = $urandom_range(4, 14);
        end else begin
          dur[c] = dur[c] - 1;
        end
      end
      if ($urandom_range(0, 799) == 0) begin
        rst = 1'b1; run(2); rst = 1'b0;
      end
      step();
    end
    check("random_saw_req", int'(n_req > 2), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
